fetch_unit: RTL

Instruction fetch front end for the single-cycle CPU datapath. Consumes 30-bit word addresses and produces the instruction stream. Owns the fetch address counter and drives word-addressed read requests to instruction memory over a req/ack handshake. Buffers returned words with their addresses in a small FIFO and hands them to decode over a valid/ready handshake. Supports redirect (taken branch/jump) with flush of stale fetches.

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch address counter, issues single-outstanding word reads to
// instruction memory over req/ack, buffers returned words with their
// addresses in a small FIFO, and hands them to decode over valid/ready.
// Redirect flushes the buffer; a read already in flight is drained and its
// data discarded.
// Optional feature: define FETCH_BYPASS_EN to forward a returning word
// straight to decode when the buffer is empty (zero-cycle latency).
module fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [29:0] RESET_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [29:0] redirect_addr,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT  = 2'd1;  // request at fetch_pc, data kept
  localparam logic [1:0] S_DRAIN = 2'd2;  // stale request, data discarded

  logic [1:0]       state_q, state_d;
  logic [29:0]      fetch_pc_q, fetch_pc_d;
  logic [29:0]      drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] mem_inst_q [FIFO_DEPTH];
  logic [29:0] mem_pc_q   [FIFO_DEPTH];

  logic fifo_empty;
  logic ack_keep;
  logic bypass_fire;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);

  // An ack in WAIT delivers a word we keep, unless a redirect kills it.
  assign ack_keep = (state_q == S_WAIT) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass_fire = fifo_empty && ack_keep;
`else
  assign bypass_fire = 1'b0;
`endif

  // A bypassed word that decode takes right away never enters the buffer.
  assign push = ack_keep && !(bypass_fire && inst_ready);
  assign pop  = !redirect && !fifo_empty && inst_ready;

  // Next-state logic for the request FSM, fetch counter and FIFO pointers.
  // NOTE: every _d gets its _q value first so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latch).
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_addr;
      case (state_q)
        S_WAIT: begin
          if (imem_ack) begin
            state_d = S_WAIT;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end
        S_DRAIN: state_d = imem_ack ? S_WAIT : S_DRAIN;
        default: state_d = S_WAIT;
      endcase
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (ack_keep) fetch_pc_d = fetch_pc_q + 30'd1;

      case (state_q)
        S_IDLE: begin
          if (count_d < DEPTH_C) state_d = S_WAIT;
        end
        S_WAIT, S_DRAIN: begin
          if (imem_ack) state_d = (count_d < DEPTH_C) ? S_WAIT : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state registers; reset drops the request immediately.
  // NOTE: registers take <= so every flop samples pre-edge values; the
  // combinational block above uses = because it describes wires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_ADDR;
      drain_addr_q <= RESET_ADDR;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Buffer storage: word and its address written together on push.
  // NOTE: storage has no reset; outputs are forced to zero while the buffer
  // is empty, so stale or unknown contents never reach decode.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;

  // Decode-side outputs: buffer head, or the returning word when bypassing.
  always_comb begin
    inst_valid = !fifo_empty;
    inst       = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst    = mem_inst_q[rd_ptr_q];
      inst_pc = mem_pc_q[rd_ptr_q];
    end else if (bypass_fire) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = imem_addr;
    end
  end

endmodule
